matrix_add_sub_sched: RTL and testbench
=======================================

Name: matrix_add_sub_sched

Overview:
- Shares one word-wide add/sub datapath between two requesters (port 0, port 1).
- Round-robin arbitration over the two requesters.
- Each granted job adds or subtracts two ROWS x COLS matrices element-serially, one element per cycle.
- Returns the full flattened result matrix to the granted requester with a valid/ready handshake.
- Sits between the matrix-math clients and the shared arithmetic resource.

Parameters:
- word_size, 32, bits per matrix element.
- ROWS, 2, matrix row count (>=1).
- COLS, 2, matrix column count (>=1).
- N (local), ROWS*COLS, element count; counter width is clog2(N), minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- req0_valid  input  1  requester 0 has a job.
- req0_ready  output  1  job from requester 0 accepted this cycle.
- req0_op  input  1  0 = A+B, 1 = A-B.
- req0_A  input  N*word_size  operand A, row-major, element (0,0) in the MSBs.
- req0_B  input  N*word_size  operand B, same layout as req0_A.
- req1_valid / req1_ready / req1_op / req1_A / req1_B: same as port 0, for requester 1.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_id  output  1  requester that owns the result.
- res_ASP  output  N*word_size  result matrix, same layout as the operands.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, rr_last=1 (port 0 has priority first).
  - All outputs 0, including res_ASP; element counter 0.
- States: IDLE -> LOAD -> CALC -> RESP -> IDLE.
- IDLE:
  - If any reqX_valid, grant one requester.
  - Both valid: grant the port not equal to rr_last. Single valid: grant that port.
  - Assert the granted reqX_ready for exactly this one cycle (combinational from state and valids).
  - Capture op, A and B into internal registers; set rr_last to the granted port; go to LOAD.
  - Requester must hold its operands stable only in the cycle where valid && ready.
- LOAD: clear the element counter and result register; go to CALC. Exists to give a fixed pipeline boundary.
- CALC:
  - Each cycle, element k = counter is computed as A[k] + B[k] or A[k] - B[k], modulo 2^word_size (carry/borrow discarded, two's complement wrap).
  - The result is written into element k of the result register.
  - When k == N-1, go to RESP; otherwise increment k.
- RESP:
  - res_valid=1, res_id=granted port, res_ASP=result register. All three stay stable while res_ready=0.
  - On res_valid && res_ready: drop res_valid next cycle and return to IDLE. res_ASP keeps its last value.
- Latency: from accept cycle (ready=1) to first res_valid is 1 (LOAD) + N (CALC) + 1 = N+2 cycles. For 2x2 that is 6 cycles.
- Throughput: at most one job per N+3 cycles, because no request is accepted outside IDLE.
- Requests arriving while busy: reqX_ready stays 0; the requester must keep valid asserted. No queuing.
- Simultaneous requests on consecutive jobs alternate strictly: 0,1,0,1...
- A request dropping valid before grant is legal; nothing is captured.
- Reset mid-job (any state): the job is abandoned, no response, all outputs 0 in the next cycle. rr_last returns to 1.
- Single-element matrices (N=1) supported: CALC lasts one cycle.

Test Plan:
- Reset then req0 only: op=0, A={1,2,3,4}, B={10,20,30,40} -> req0_ready pulses 1 cycle; res_valid 6 cycles later with res_id=0, res_ASP={11,22,33,44}.
- Subtract with wrap: req1, op=1, A={0,5,7,0xFFFFFFFF}, B={1,5,8,1} -> res_ASP={0xFFFFFFFF,0,0xFFFFFFFF,0xFFFFFFFE}, res_id=1.
- Both requesters held valid for 4 jobs -> grants in order 0,1,0,1. Each res_id matches its grant. No ready is asserted while busy=1.
- Backpressure: hold res_ready=0 for 10 cycles in RESP -> res_valid, res_id and res_ASP stay constant. A pending req0_valid stays unacknowledged. Raising res_ready returns to IDLE and grants req0 the next cycle.
- Reset asserted in CALC cycle 2 -> next cycle busy=0, res_valid=0, res_ASP=0. A following single req1 job completes normally.
- ROWS=1, COLS=1 build: A={7}, B={9}, op=1 -> res_ASP=0xFFFFFFFE, 3 cycles after accept.

Source files
------------

// File: rtl/matrix_add_sub_sched.sv
// Two-port round-robin scheduler in front of one shared add/sub datapath.
// A granted job is processed one matrix element per cycle and the complete
// flattened result is handed back to its owner with a valid/ready handshake.
module matrix_add_sub_sched #(
    parameter int word_size = 32,
    parameter int ROWS      = 2,
    parameter int COLS      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req0_valid,
    output logic                              req0_ready,
    input  logic                              req0_op,
    input  logic [ROWS*COLS*word_size-1:0]    req0_A,
    input  logic [ROWS*COLS*word_size-1:0]    req0_B,
    input  logic                              req1_valid,
    output logic                              req1_ready,
    input  logic                              req1_op,
    input  logic [ROWS*COLS*word_size-1:0]    req1_A,
    input  logic [ROWS*COLS*word_size-1:0]    req1_B,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic                              res_id,
    output logic [ROWS*COLS*word_size-1:0]    res_ASP,
    output logic                              busy
);

    localparam int N  = ROWS * COLS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int MW = N * word_size;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CALC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_rr_last;
    logic                  r_id;
    logic                  r_op;
    logic [MW-1:0]         r_a;
    logic [MW-1:0]         r_b;
    logic [CW-1:0]         r_cnt;
    logic [word_size-1:0]  r_res_el [N];

    logic                  w_grant_any;
    logic                  w_grant_id;
    logic [word_size-1:0]  w_a_el [N];
    logic [word_size-1:0]  w_b_el [N];
    logic [word_size-1:0]  w_a_cur;
    logic [word_size-1:0]  w_b_cur;
    logic [word_size-1:0]  w_res;

    // Next-state, grant selection and the one-cycle ready pulse.
    always_comb begin
        w_state_next = r_state;
        w_grant_any  = 1'b0;
        w_grant_id   = 1'b0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req0_valid || req1_valid) begin
                    w_grant_any = 1'b1;
                    // On contention the port that was not served last wins.
                    if (req0_valid && req1_valid)
                        w_grant_id = ~r_rr_last;
                    else
                        w_grant_id = req1_valid;
                    req0_ready   = ~w_grant_id;
                    req1_ready   = w_grant_id;
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: w_state_next = S_CALC;
            S_CALC: begin
                if (r_cnt == LAST)
                    w_state_next = S_RESP;
            end
            S_RESP: begin
                if (res_ready)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        // A grant during reset would be silently discarded, so never advertise one.
        if (rst) begin
            w_grant_any = 1'b0;
            req0_ready  = 1'b0;
            req1_ready  = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    // Job capture at grant time and round-robin history.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
            r_id      <= 1'b0;
            r_op      <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
        end else if (w_grant_any) begin
            r_rr_last <= w_grant_id;
            r_id      <= w_grant_id;
            r_op      <= w_grant_id ? req1_op : req0_op;
            r_a       <= w_grant_id ? req1_A  : req0_A;
            r_b       <= w_grant_id ? req1_B  : req0_B;
        end
    end

    // Element counter: cleared in LOAD, walks 0..N-1 through CALC.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_LOAD)
            r_cnt <= '0;
        else if (r_state == S_CALC && r_cnt != LAST)
            r_cnt <= r_cnt + 1'b1;
    end

    // Unpack operands; element 0 lives in the most significant word.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign w_a_el[gi] = r_a[(N-1-gi)*word_size +: word_size];
            assign w_b_el[gi] = r_b[(N-1-gi)*word_size +: word_size];
        end
    endgenerate

    // The single shared add/sub unit; carry and borrow simply wrap.
    assign w_a_cur = w_a_el[r_cnt];
    assign w_b_cur = w_b_el[r_cnt];
    assign w_res   = r_op ? (w_a_cur - w_b_cur) : (w_a_cur + w_b_cur);

    // Result words: each one is written only in its own CALC slot.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_res
            always_ff @(posedge clk) begin
                if (rst || r_state == S_LOAD)
                    r_res_el[gi] <= '0;
                else if (r_state == S_CALC && r_cnt == CW'(gi))
                    r_res_el[gi] <= w_res;
            end
            assign res_ASP[(N-1-gi)*word_size +: word_size] = r_res_el[gi];
        end
    endgenerate

    assign res_valid = (r_state == S_RESP);
    assign res_id    = r_id;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_matrix_add_sub_sched.sv
// Directed bench for matrix_add_sub_sched: a 2x2 instance exercising
// arbitration, arithmetic, backpressure and reset, plus a 1x1 instance.
module tb_matrix_add_sub_sched;

    localparam int W   = 32;
    localparam int MW  = 4 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_op;
    logic [MW-1:0] req0_A, req0_B;
    logic          req1_valid, req1_ready, req1_op;
    logic [MW-1:0] req1_A, req1_B;
    logic          res_valid, res_ready, res_id, busy;
    logic [MW-1:0] res_ASP;

    // 1x1 instance signals
    logic          s0_valid, s0_ready, s0_op;
    logic [W-1:0]  s0_A, s0_B;
    logic          s1_valid, s1_ready, s1_op;
    logic [W-1:0]  s1_A, s1_B;
    logic          s_res_valid, s_res_ready, s_res_id, s_busy;
    logic [W-1:0]  s_res_ASP;

    int n_vec = 0;
    int n_err = 0;

    // Hand-computed operand / result sets
    localparam logic [MW-1:0] ADD_A = {32'd1, 32'd2, 32'd3, 32'd4};
    localparam logic [MW-1:0] ADD_B = {32'd10, 32'd20, 32'd30, 32'd40};
    localparam logic [MW-1:0] ADD_R = {32'd11, 32'd22, 32'd33, 32'd44};
    localparam logic [MW-1:0] SUB_A = {32'd0, 32'd5, 32'd7, 32'hFFFF_FFFF};
    localparam logic [MW-1:0] SUB_B = {32'd1, 32'd5, 32'd8, 32'd1};
    localparam logic [MW-1:0] SUB_R = {32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    always #5 clk = ~clk;

    matrix_add_sub_sched #(.word_size(W), .ROWS(2), .COLS(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_A(req0_A), .req0_B(req0_B),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_A(req1_A), .req1_B(req1_B),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_ASP(res_ASP), .busy(busy)
    );

    matrix_add_sub_sched #(.word_size(W), .ROWS(1), .COLS(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(s0_valid), .req0_ready(s0_ready), .req0_op(s0_op),
        .req0_A(s0_A), .req0_B(s0_B),
        .req1_valid(s1_valid), .req1_ready(s1_ready), .req1_op(s1_op),
        .req1_A(s1_A), .req1_B(s1_B),
        .res_valid(s_res_valid), .res_ready(s_res_ready), .res_id(s_res_id),
        .res_ASP(s_res_ASP), .busy(s_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called one cycle after the accept edge; returns cycles counted from accept.
    task automatic wait_resp(output int cyc);
        cyc = 1;
        while (!res_valid && cyc < 30) begin
            check("no_ready_while_busy", {126'd0, req1_ready, req0_ready}, '0);
            tick();
            cyc++;
        end
        check("resp_timeout", {127'd0, res_valid}, 1);
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("valid_drops", {127'd0, res_valid}, 0);
        check("idle_after_resp", {127'd0, busy}, 0);
    endtask

    // Single-requester job with latency and result checks.
    task automatic run_job(input bit port, input bit op, input logic [MW-1:0] a,
                           input logic [MW-1:0] b, input logic [MW-1:0] exp);
        int cyc;
        if (port) begin
            req1_op = op; req1_A = a; req1_B = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_A = a; req0_B = b; req0_valid = 1'b1;
        end
        #1;
        check("accept_ready", {126'd0, req1_ready, req0_ready}, port ? 2 : 1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("busy_after_accept", {127'd0, busy}, 1);
        check("ready_one_cycle", {126'd0, req1_ready, req0_ready}, 0);
        wait_resp(cyc);
        check("latency", MW'(cyc), 6);
        check("res_id", {127'd0, res_id}, MW'(port));
        check("res_ASP", res_ASP, exp);
        handshake();
    endtask

    initial begin
        int cyc;
        logic [1:0] exp_rdy;
        rst = 1'b1;
        req0_valid = 0; req0_op = 0; req0_A = '0; req0_B = '0;
        req1_valid = 0; req1_op = 0; req1_A = '0; req1_B = '0;
        res_ready = 0;
        s0_valid = 0; s0_op = 0; s0_A = '0; s0_B = '0;
        s1_valid = 0; s1_op = 0; s1_A = '0; s1_B = '0;
        s_res_ready = 0;
        repeat (2) tick();

        // Reset state
        check("rst_busy", {127'd0, busy}, 0);
        check("rst_res_valid", {127'd0, res_valid}, 0);
        check("rst_res_id", {127'd0, res_id}, 0);
        check("rst_res_ASP", res_ASP, 0);
        check("rst_readies", {126'd0, req1_ready, req0_ready}, 0);
        check("rst_1x1_busy", {127'd0, s_busy}, 0);
        rst = 1'b0;
        tick();

        // Port 0 add, then port 1 subtract with wrap-around
        run_job(1'b0, 1'b0, ADD_A, ADD_B, ADD_R);
        run_job(1'b1, 1'b1, SUB_A, SUB_B, SUB_R);

        // Both ports held valid: grants must alternate 0,1,0,1
        req0_op = 0; req0_A = ADD_A; req0_B = ADD_B; req0_valid = 1'b1;
        req1_op = 1; req1_A = SUB_A; req1_B = SUB_B; req1_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            exp_rdy = (j % 2 == 1) ? 2'b10 : 2'b01;
            check("rr_grant", {126'd0, req1_ready, req0_ready}, MW'(exp_rdy));
            tick();
            wait_resp(cyc);
            check("rr_res_id", {127'd0, res_id}, MW'(j % 2));
            check("rr_res_ASP", res_ASP, (j % 2 == 1) ? SUB_R : ADD_R);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
        req0_valid = 0;
        req1_valid = 0;
        tick();

        // Backpressure: port 1 job held in RESP while port 0 waits
        req1_op = 1; req1_A = SUB_A; req1_B = SUB_B; req1_valid = 1'b1;
        #1;
        check("bp_accept1", {126'd0, req1_ready, req0_ready}, 2);
        tick();
        req1_valid = 1'b0;
        req0_op = 0; req0_A = ADD_A; req0_B = ADD_B; req0_valid = 1'b1;
        wait_resp(cyc);
        for (int k = 0; k < 10; k++) begin
            check("bp_valid", {127'd0, res_valid}, 1);
            check("bp_id", {127'd0, res_id}, 1);
            check("bp_data", res_ASP, SUB_R);
            check("bp_req0_pending", {127'd0, req0_ready}, 0);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp_grant0_next", {126'd0, req1_ready, req0_ready}, 1);
        tick();
        req0_valid = 1'b0;
        wait_resp(cyc);
        check("bp_job0_id", {127'd0, res_id}, 0);
        check("bp_job0_data", res_ASP, ADD_R);
        handshake();

        // Reset during the second CALC cycle abandons the job
        req1_op = 1; req1_A = SUB_A; req1_B = SUB_B; req1_valid = 1'b1;
        #1;
        tick();
        req1_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", {127'd0, busy}, 0);
        check("midrst_res_valid", {127'd0, res_valid}, 0);
        check("midrst_res_ASP", res_ASP, 0);
        check("midrst_res_id", {127'd0, res_id}, 0);
        run_job(1'b1, 1'b1, SUB_A, SUB_B, SUB_R);

        // 1x1 instance: 7 - 9 wraps, response 3 cycles after accept
        s0_op = 1; s0_A = 32'd7; s0_B = 32'd9; s0_valid = 1'b1;
        #1;
        check("n1_accept", {127'd0, s0_ready}, 1);
        tick();
        s0_valid = 1'b0;
        cyc = 1;
        while (!s_res_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        check("n1_latency", MW'(cyc), 3);
        check("n1_res_ASP", MW'(s_res_ASP), MW'(32'hFFFF_FFFE));
        check("n1_res_id", {127'd0, s_res_id}, 0);
        s_res_ready = 1'b1;
        tick();
        s_res_ready = 1'b0;
        check("n1_idle", {127'd0, s_busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
